// File: rtl/alu_design.sv
// alu_design: registered arithmetic/logic unit with operand-valid
// qualification, clock enable and status flags.
//
// Ports:
//   CLK        rising-edge clock
//   RST        asynchronous active-low reset
//   CE         clock enable; 0 holds all outputs and internal state
//   INP_VALID  operand valid: [0] = OPA, [1] = OPB
//   MODE       1 = arithmetic, 0 = logical
//   CMD        operation select
//   OPA, OPB   operands
//   CIN        carry/borrow in
//   RES        result, zero-extended to 2*DW bits
//   COUT       carry out (add) / borrow (subtract)
//   OFLOW      overflow/underflow indication
//   G, E, L    compare results (CMP only)
//   ERR        illegal command, missing operand or illegal rotate amount
//
// Multiplies (MODE=1, CMD 9/10) capture operands at the issue edge and
// deliver their product one edge later. Results always leave in issue
// order: a command issued while a multiply is still outstanding is parked
// in a one-entry holding register and delivered on the following edge.
module alu_design #(
    parameter int DW = 8,
    parameter int CW = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CE,
    input  logic [1:0]      INP_VALID,
    input  logic            MODE,
    input  logic [CW-1:0]   CMD,
    input  logic [DW-1:0]   OPA,
    input  logic [DW-1:0]   OPB,
    input  logic            CIN,
    output logic [2*DW-1:0] RES,
    output logic            COUT,
    output logic            OFLOW,
    output logic            G,
    output logic            E,
    output logic            L,
    output logic            ERR
);

    localparam int RW = 2 * DW;
    localparam int SW = $clog2(DW);

    typedef struct packed {
        logic [RW-1:0] res;
        logic          cout;
        logic          oflow;
        logic          g;
        logic          e;
        logic          l;
        logic          err;
    } result_t;

    typedef enum logic [1:0] {
        PEND_NONE,   // nothing outstanding, results go straight out
        PEND_RES,    // an older single-cycle result waits in skid_q
        PEND_MUL     // an older multiply waits in the operand stage
    } pend_e;

    pend_e         pend_q;
    result_t       out_q;
    result_t       skid_q;
    logic [DW-1:0] ma_q;
    logic [DW-1:0] mb_q;
    logic          msel_q;

    result_t       cur_d;
    result_t       mul_d;
    logic [31:0]   cmd_n;
    logic          is_mul;
    logic          need_a;
    logic          need_b;
    logic          legal;
    logic [DW:0]   sum;
    logic [DW:0]   step;
    logic [DW-1:0] diff;
    logic [DW-1:0] lg;
    logic [SW-1:0] shamt;
    logic [SW:0]   inv;
    logic [DW:0]   mul_a;
    logic [DW:0]   mul_b;

    assign cmd_n  = 32'(CMD);
    assign is_mul = MODE && (cmd_n == 32'd9 || cmd_n == 32'd10) && (INP_VALID == 2'b11);
    assign shamt  = OPB[SW-1:0];
    assign inv    = (SW+1)'(DW) - {1'b0, shamt};

    // Single-cycle result for the command presented this cycle.
    always_comb begin
        cur_d  = '0;
        need_a = 1'b0;
        need_b = 1'b0;
        legal  = 1'b1;
        sum    = '0;
        step   = '0;
        diff   = '0;
        lg     = '0;
        if (MODE) begin
            case (cmd_n)
                0, 2: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    sum = {1'b0, OPA} + {1'b0, OPB} + ((cmd_n == 32'd2) ? (DW+1)'(CIN) : '0);
                    cur_d.res  = RW'(sum[DW-1:0]);
                    cur_d.cout = sum[DW];
                end
                1, 3: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    if (cmd_n == 32'd3) begin
                        diff = OPA - OPB - DW'(CIN);
                        cur_d.oflow = {1'b0, OPA} < ({1'b0, OPB} + (DW+1)'(CIN));
                    end else begin
                        diff = OPA - OPB;
                        cur_d.oflow = OPA < OPB;
                    end
                    cur_d.res  = RW'(diff);
                    cur_d.cout = cur_d.oflow;
                end
                4: begin
                    need_a = 1'b1;
                    step = {1'b0, OPA} + (DW+1)'(1);
                    cur_d.res   = RW'(step);
                    cur_d.oflow = &OPA;
                end
                5: begin
                    need_a = 1'b1;
                    step = {1'b0, OPA} - (DW+1)'(1);
                    cur_d.res   = RW'(step);
                    cur_d.oflow = (OPA == '0);
                end
                6: begin
                    need_b = 1'b1;
                    step = {1'b0, OPB} + (DW+1)'(1);
                    cur_d.res   = RW'(step);
                    cur_d.oflow = &OPB;
                end
                7: begin
                    need_b = 1'b1;
                    step = {1'b0, OPB} - (DW+1)'(1);
                    cur_d.res   = RW'(step);
                    cur_d.oflow = (OPB == '0);
                end
                8: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    cur_d.g = OPA > OPB;
                    cur_d.e = OPA == OPB;
                    cur_d.l = OPA < OPB;
                end
                9, 10: begin
                    // Valid multiplies bypass this path; only the error case lands here.
                    need_a = 1'b1;
                    need_b = 1'b1;
                end
                default: legal = 1'b0;
            endcase
        end else begin
            case (cmd_n)
                0:  begin need_a = 1'b1; need_b = 1'b1; lg = OPA & OPB;     end
                1:  begin need_a = 1'b1; need_b = 1'b1; lg = ~(OPA & OPB);  end
                2:  begin need_a = 1'b1; need_b = 1'b1; lg = OPA | OPB;     end
                3:  begin need_a = 1'b1; need_b = 1'b1; lg = ~(OPA | OPB);  end
                4:  begin need_a = 1'b1; need_b = 1'b1; lg = OPA ^ OPB;     end
                5:  begin need_a = 1'b1; need_b = 1'b1; lg = ~(OPA ^ OPB);  end
                6:  begin need_a = 1'b1; lg = ~OPA;                         end
                7:  begin need_b = 1'b1; lg = ~OPB;                         end
                8:  begin need_a = 1'b1; lg = OPA >> 1;                     end
                9:  begin need_a = 1'b1; lg = OPA << 1;                     end
                10: begin need_b = 1'b1; lg = OPB >> 1;                     end
                11: begin need_b = 1'b1; lg = OPB << 1;                     end
                12: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    lg = (OPA << shamt) | (OPA >> inv);
                    cur_d.err = |OPB[DW-1:SW];
                end
                13: begin
                    need_a = 1'b1;
                    need_b = 1'b1;
                    lg = (OPA >> shamt) | (OPA << inv);
                    cur_d.err = |OPB[DW-1:SW];
                end
                default: legal = 1'b0;
            endcase
            cur_d.res = RW'(lg);
        end
        if (!legal || (need_a && !INP_VALID[0]) || (need_b && !INP_VALID[1])) begin
            cur_d     = '0;
            cur_d.err = 1'b1;
        end
    end

    // Second-cycle multiply from the captured operands.
    always_comb begin
        mul_d = '0;
        if (msel_q) begin
            mul_a = {1'b0, ma_q[DW-2:0], 1'b0};
            mul_b = {1'b0, mb_q};
        end else begin
            mul_a = {1'b0, ma_q} + (DW+1)'(1);
            mul_b = {1'b0, mb_q} + (DW+1)'(1);
        end
        mul_d.res = RW'(mul_a) * RW'(mul_b);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pend_q <= PEND_NONE;
            out_q  <= '0;
            skid_q <= '0;
            ma_q   <= '0;
            mb_q   <= '0;
            msel_q <= 1'b0;
        end else if (CE) begin
            // Oldest outstanding result leaves first.
            case (pend_q)
                PEND_RES: out_q <= skid_q;
                PEND_MUL: out_q <= mul_d;
                default:  if (!is_mul) out_q <= cur_d;
            endcase
            if (is_mul) begin
                ma_q   <= OPA;
                mb_q   <= OPB;
                msel_q <= (cmd_n == 32'd10);
                pend_q <= PEND_MUL;
            end else if (pend_q != PEND_NONE) begin
                skid_q <= cur_d;
                pend_q <= PEND_RES;
            end
        end
    end

    assign RES   = out_q.res;
    assign COUT  = out_q.cout;
    assign OFLOW = out_q.oflow;
    assign G     = out_q.g;
    assign E     = out_q.e;
    assign L     = out_q.l;
    assign ERR   = out_q.err;

endmodule

// File: tb/tb_alu_design.sv
// Directed bench for alu_design (DW=8, CW=4). Inputs change 1 ns after a
// rising edge; outputs are compared 1 ns after the edge that registers them.
// Flag vectors are ordered {COUT, OFLOW, G, E, L, ERR}.
module tb_alu_design;

    logic        CLK;
    logic        RST;
    logic        CE;
    logic [1:0]  INP_VALID;
    logic        MODE;
    logic [3:0]  CMD;
    logic [7:0]  OPA;
    logic [7:0]  OPB;
    logic        CIN;
    logic [15:0] RES;
    logic        COUT, OFLOW, G, E, L, ERR;

    int checks = 0;
    int errors = 0;

    alu_design #(.DW(8), .CW(4)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .INP_VALID(INP_VALID), .MODE(MODE),
        .CMD(CMD), .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .COUT(COUT),
        .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] c, input logic [1:0] v,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
        MODE      = m;
        CMD       = c;
        INP_VALID = v;
        OPA       = a;
        OPB       = b;
        CIN       = ci;
    endtask

    task automatic check(input string tag, input logic [15:0] exp_res, input logic [5:0] exp_flags);
        logic [21:0] obs;
        logic [21:0] exp;
        obs = {RES, COUT, OFLOW, G, E, L, ERR};
        exp = {exp_res, exp_flags};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed res=%h flags=%b, expected res=%h flags=%b",
                   tag, obs[21:6], obs[5:0], exp_res, exp_flags);
        end
    endtask

    initial begin
        RST = 1'b0;
        CE  = 1'b1;
        drive(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        check("reset_init", 16'h0000, 6'b000000);
        RST = 1'b1;

        drive(1'b1, 4'd0, 2'b11, 8'hFF, 8'h01, 1'b0); tick();
        check("add_carry", 16'h0000, 6'b100000);
        drive(1'b1, 4'd1, 2'b11, 8'd5, 8'd9, 1'b0); tick();
        check("sub_borrow", 16'h00FC, 6'b110000);
        drive(1'b1, 4'd2, 2'b11, 8'd10, 8'd20, 1'b1); tick();
        check("add_cin", 16'd31, 6'b000000);
        drive(1'b1, 4'd3, 2'b11, 8'd5, 8'd4, 1'b1); tick();
        check("sub_cin_edge", 16'h0000, 6'b000000);
        drive(1'b1, 4'd4, 2'b01, 8'hFF, 8'h55, 1'b0); tick();
        check("inc_a_wrap", 16'h0100, 6'b010000);
        drive(1'b1, 4'd7, 2'b10, 8'h12, 8'h00, 1'b0); tick();
        check("dec_b_zero", 16'h01FF, 6'b010000);
        drive(1'b1, 4'd8, 2'b11, 8'd7, 8'd7, 1'b0); tick();
        check("cmp_eq", 16'h0000, 6'b000100);
        drive(1'b1, 4'd8, 2'b11, 8'd9, 8'd3, 1'b0); tick();
        check("cmp_gt", 16'h0000, 6'b001000);
        drive(1'b1, 4'd8, 2'b11, 8'd2, 8'd200, 1'b0); tick();
        check("cmp_lt", 16'h0000, 6'b000010);
        drive(1'b0, 4'd1, 2'b11, 8'hF0, 8'h3C, 1'b0); tick();
        check("nand", 16'h00CF, 6'b000000);
        drive(1'b0, 4'd12, 2'b11, 8'b1000_0001, 8'h01, 1'b0); tick();
        check("rol1", 16'h0003, 6'b000000);
        drive(1'b0, 4'd13, 2'b11, 8'b1000_0001, 8'h10, 1'b0); tick();
        check("ror_bad_amt", 16'h0081, 6'b000001);
        drive(1'b0, 4'd10, 2'b10, 8'h00, 8'h81, 1'b0); tick();
        check("shr1_b", 16'h0040, 6'b000000);
        drive(1'b0, 4'd15, 2'b11, 8'h12, 8'h34, 1'b0); tick();
        check("logic_illegal", 16'h0000, 6'b000001);
        drive(1'b1, 4'd4, 2'b01, 8'h10, 8'h00, 1'b0); tick();
        check("inc_a", 16'h0011, 6'b000000);
        drive(1'b1, 4'd0, 2'b01, 8'h01, 8'h02, 1'b0); tick();
        check("add_missing_b", 16'h0000, 6'b000001);

        CE = 1'b0;
        drive(1'b1, 4'd0, 2'b11, 8'h01, 8'h01, 1'b0); tick();
        drive(1'b0, 4'd2, 2'b11, 8'h0F, 8'hF0, 1'b0); tick();
        check("ce_hold", 16'h0000, 6'b000001);
        CE = 1'b1;

        // Multiply at the issue edge, then a new command while it is outstanding.
        drive(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0); tick();
        drive(1'b1, 4'd8, 2'b11, 8'd9, 8'd3, 1'b0); tick();
        check("mul9", 16'd20, 6'b000000);
        drive(1'b1, 4'd10, 2'b11, 8'd2, 8'd5, 1'b0); tick();
        check("cmp_after_mul", 16'h0000, 6'b001000);
        drive(1'b1, 4'd9, 2'b11, 8'hFF, 8'hFF, 1'b0); tick();
        check("mul10", 16'd20, 6'b000000);
        drive(1'b1, 4'd0, 2'b11, 8'd1, 8'd2, 1'b0); tick();
        check("mul9_wrap", 16'h0000, 6'b000000);
        drive(1'b1, 4'd9, 2'b11, 8'd3, 8'd4, 1'b0); tick();
        check("add_after_mul", 16'h0003, 6'b000000);

        // Asynchronous reset between edges while a multiply is outstanding.
        #3 RST = 1'b0;
        #1 check("reset_async", 16'h0000, 6'b000000);
        #1 RST = 1'b1;
        drive(1'b1, 4'd0, 2'b11, 8'd2, 8'd2, 1'b0); tick();
        check("post_reset_add", 16'h0004, 6'b000000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
